// File: rtl/tia_hsync_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tia_hsync_sequencer                                          |
// | Description : Horizontal-timing controller for the TIA core. Divides the   |
// |               colour clock into phi1/phi2 biphase strobes, steps a 6-bit   |
// |               XNOR LFSR horizontal counter once per biphase period, decodes |
// |               HSYNC / HBLANK / colour-burst, drives CPU RDY for WSYNC and   |
// |               restarts the line on RSYNC.                                  |
// | Ports       : clk        in  colour clock, all state changes on posedge    |
// |               rl         in  asynchronous reset, active low                |
// |               rsync      in  one-clk strobe, restart line                  |
// |               wsync      in  one-clk strobe, halt CPU until next line      |
// |               hmove      in  one-clk strobe, mark line as HMOVE            |
// |               phi1/phi2  out biphase strobes, each high one clk in four    |
// |               hcount     out LFSR counter state (6 bit)                    |
// |               hindex     out binary line index 0..LINE_LEN-1 (6 bit)       |
// |               hsync, hblank, cburst  out line event windows                |
// |               rdy        out CPU ready, low = halted                       |
// |               line_start out one-clk pulse when the index returns to 0     |
// | Options     : TIA_LATE_HBLANK_EN - when defined, hmove extends hblank to   |
// |               LRHB_IDX on the marked line; otherwise hmove is ignored.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tia_hsync_sequencer #(
    parameter int LINE_LEN = 57,
    parameter int SHS_IDX  = 4,
    parameter int RHS_IDX  = 8,
    parameter int RCB_IDX  = 12,
    parameter int RHB_IDX  = 16,
    parameter int LRHB_IDX = 18
) (
    input  logic       clk,
    input  logic       rl,
    input  logic       rsync,
    input  logic       wsync,
    input  logic       hmove,
    output logic       phi1,
    output logic       phi2,
    output logic [5:0] hcount,
    output logic [5:0] hindex,
    output logic       hsync,
    output logic       hblank,
    output logic       cburst,
    output logic       rdy,
    output logic       line_start
);

    localparam logic [5:0] C_LAST_IDX = 6'(LINE_LEN - 1);
    localparam logic [5:0] C_SHS_IDX  = 6'(SHS_IDX);
    localparam logic [5:0] C_RHS_IDX  = 6'(RHS_IDX);
    localparam logic [5:0] C_RCB_IDX  = 6'(RCB_IDX);
    localparam logic [5:0] C_RHB_IDX  = 6'(RHB_IDX);
    localparam logic [5:0] C_LRHB_IDX = 6'(LRHB_IDX);

    logic [1:0] ph_q, ph_d;
    logic       phi1_q, phi1_d;
    logic       phi2_q, phi2_d;
    logic [5:0] hcount_q, hcount_d;
    logic [5:0] hindex_q, hindex_d;
    logic       hsync_q, hsync_d;
    logic       hblank_q, hblank_d;
    logic       cburst_q, cburst_d;
    logic       rdy_q, rdy_d;
    logic       line_start_q, line_start_d;
    logic       w_late;
    logic       w_step;

`ifdef TIA_LATE_HBLANK_EN
    logic late_q, late_d;
    assign w_late = late_q;
`else
    logic w_unused_hmove;
    assign w_late         = 1'b0;
    assign w_unused_hmove = hmove;
`endif

    // The counter advances on the last clock of each biphase period (after phi2).
    assign w_step = (ph_q == 2'd3);

    always_comb begin
        ph_d         = ph_q + 2'd1;
        hcount_d     = hcount_q;
        hindex_d     = hindex_q;
        hsync_d      = hsync_q;
        hblank_d     = hblank_q;
        cburst_d     = cburst_q;
        rdy_d        = rdy_q;
        line_start_d = 1'b0;
`ifdef TIA_LATE_HBLANK_EN
        late_d       = late_q;
`endif

        if (w_step) begin
            if (hindex_q == C_LAST_IDX) begin
                hcount_d     = 6'd0;
                hindex_d     = 6'd0;
                line_start_d = 1'b1;
            end else begin
                hcount_d = {hcount_q[4:0], ~(hcount_q[5] ^ hcount_q[4])};
                hindex_d = hindex_q + 6'd1;
            end

            // Event decode keys off the index being entered, not the one left.
            if (hindex_d == 6'd0) begin
                hblank_d = 1'b1;
`ifdef TIA_LATE_HBLANK_EN
                late_d   = 1'b0;
`endif
            end
            if (hindex_d == C_SHS_IDX) begin
                hsync_d = 1'b1;
            end
            if (hindex_d == C_RHS_IDX) begin
                hsync_d  = 1'b0;
                cburst_d = 1'b1;
            end
            if (hindex_d == C_RCB_IDX) begin
                cburst_d = 1'b0;
            end
            if ((hindex_d == C_RHB_IDX) && !w_late) begin
                hblank_d = 1'b0;
            end
            if ((hindex_d == C_LRHB_IDX) && w_late) begin
                hblank_d = 1'b0;
            end
        end

`ifdef TIA_LATE_HBLANK_EN
        // Placed after the wrap clear so an HMOVE on the wrap edge marks the new line.
        if (hmove) begin
            late_d = 1'b1;
        end
`endif

        // Line restart overrides any step or wrap on the same edge.
        if (rsync) begin
            ph_d         = 2'd0;
            hcount_d     = 6'd0;
            hindex_d     = 6'd0;
            hblank_d     = 1'b1;
            hsync_d      = 1'b0;
            cburst_d     = 1'b0;
            line_start_d = 1'b1;
`ifdef TIA_LATE_HBLANK_EN
            late_d       = 1'b0;
`endif
        end

        // A WSYNC landing on the line_start cycle must wait for the next line.
        if (wsync) begin
            rdy_d = 1'b0;
        end else if (line_start_q) begin
            rdy_d = 1'b1;
        end

        phi1_d = (ph_d == 2'd0);
        phi2_d = (ph_d == 2'd2);
    end

    always_ff @(posedge clk or negedge rl) begin
        if (!rl) begin
            ph_q         <= 2'd0;
            phi1_q       <= 1'b1;
            phi2_q       <= 1'b0;
            hcount_q     <= 6'd0;
            hindex_q     <= 6'd0;
            hsync_q      <= 1'b0;
            hblank_q     <= 1'b1;
            cburst_q     <= 1'b0;
            rdy_q        <= 1'b1;
            line_start_q <= 1'b0;
        end else begin
            ph_q         <= ph_d;
            phi1_q       <= phi1_d;
            phi2_q       <= phi2_d;
            hcount_q     <= hcount_d;
            hindex_q     <= hindex_d;
            hsync_q      <= hsync_d;
            hblank_q     <= hblank_d;
            cburst_q     <= cburst_d;
            rdy_q        <= rdy_d;
            line_start_q <= line_start_d;
        end
    end

`ifdef TIA_LATE_HBLANK_EN
    always_ff @(posedge clk or negedge rl) begin
        if (!rl) begin
            late_q <= 1'b0;
        end else begin
            late_q <= late_d;
        end
    end
`endif

    assign phi1       = phi1_q;
    assign phi2       = phi2_q;
    assign hcount     = hcount_q;
    assign hindex     = hindex_q;
    assign hsync      = hsync_q;
    assign hblank     = hblank_q;
    assign cburst     = cburst_q;
    assign rdy        = rdy_q;
    assign line_start = line_start_q;

endmodule
`default_nettype wire

// File: tb/tb_tia_hsync_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tia_hsync_sequencer                                       |
// | Description : Self-checking bench for tia_hsync_sequencer. Expected values |
// |               are queued when stimulus is applied and compared when the    |
// |               design produces the corresponding output.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tia_hsync_sequencer;

    logic       clk;
    logic       rl;
    logic       rsync;
    logic       wsync;
    logic       hmove;
    logic       phi1;
    logic       phi2;
    logic [5:0] hcount;
    logic [5:0] hindex;
    logic       hsync;
    logic       hblank;
    logic       cburst;
    logic       rdy;
    logic       line_start;

    int unsigned exp_q[$];
    int          n_cmp;
    int          n_err;

    localparam logic [18:0] C_RESET_VEC = 19'b1_0_000000_000000_0_1_0_1_0;

`ifdef TIA_LATE_HBLANK_EN
    localparam int C_LATE_FALL_IDX = 18;
    localparam int C_LATE_LEN      = 72;
`else
    localparam int C_LATE_FALL_IDX = 16;
    localparam int C_LATE_LEN      = 64;
`endif

    tia_hsync_sequencer dut (
        .clk        (clk),
        .rl         (rl),
        .rsync      (rsync),
        .wsync      (wsync),
        .hmove      (hmove),
        .phi1       (phi1),
        .phi2       (phi2),
        .hcount     (hcount),
        .hindex     (hindex),
        .hsync      (hsync),
        .hblank     (hblank),
        .cburst     (cburst),
        .rdy        (rdy),
        .line_start (line_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lfsr_next(input logic [5:0] x);
        return {x[4:0], ~(x[5] ^ x[4])};
    endfunction

    function automatic logic [18:0] out_vec();
        return {phi1, phi2, hcount, hindex, hsync, hblank, cburst, rdy, line_start};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_idx(input int idx);
        int n;
        n = 0;
        while (!(hindex == idx[5:0] && phi1 === 1'b1) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL goto_idx: index %0d not reached, hindex=%0d", idx, hindex);
        end
    endtask

    task automatic wait_line_start();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (line_start !== 1'b1 && n < 300);
        if (line_start !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_line_start: no pulse within 300 clk, line_start=%b", line_start);
        end
    endtask

    task automatic test_reset();
        rl = 1'b0; rsync = 1'b0; wsync = 1'b0; hmove = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_vec() !== C_RESET_VEC) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", out_vec(), C_RESET_VEC);
        end
        rl = 1'b1;
    endtask

    task automatic test_free_run();
        logic [5:0]  seed_tab [7];
        logic [5:0]  val;
        logic [5:0]  prev;
        int unsigned e;
        int hs_cnt, hs_first, cb_cnt, cb_first, hb_cnt;
        seed_tab = '{6'h00, 6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};
        prev = 6'h00;
        for (int i = 0; i < 57; i++) begin
            val = (i < 7) ? seed_tab[i] : lfsr_next(prev);
            exp_q.push_back(int'(val));
            prev = val;
        end
        hs_cnt = 0; hs_first = -1; cb_cnt = 0; cb_first = -1; hb_cnt = 0;
        for (int k = 0; k < 228; k++) begin
            n_cmp++;
            if (phi1 !== (k % 4 == 0) || phi2 !== (k % 4 == 2)) begin
                n_err++;
                $display("FAIL phase k=%0d: phi1=%b phi2=%b expected %b %b",
                         k, phi1, phi2, (k % 4 == 0), (k % 4 == 2));
            end
            if (k % 4 == 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (hcount !== e[5:0] || hindex !== 6'(k / 4)) begin
                    n_err++;
                    $display("FAIL counter k=%0d: hcount=%h hindex=%0d expected %h %0d",
                             k, hcount, hindex, e[5:0], k / 4);
                end
            end
            n_cmp++;
            if (line_start !== 1'b0) begin
                n_err++;
                $display("FAIL line_start_early k=%0d: got %b expected 0", k, line_start);
            end
            if (hsync === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (cburst === 1'b1) begin
                cb_cnt++;
                if (cb_first < 0) cb_first = k;
            end
            if (hblank === 1'b1) hb_cnt++;
            tick();
        end
        n_cmp++;
        if (line_start !== 1'b1 || hindex !== 6'd0 || hcount !== 6'd0 || phi1 !== 1'b1) begin
            n_err++;
            $display("FAIL wrap: line_start=%b hindex=%0d hcount=%h phi1=%b expected 1 0 00 1",
                     line_start, hindex, hcount, phi1);
        end
        n_cmp++;
        if (hs_cnt != 16 || hs_first != 16) begin
            n_err++;
            $display("FAIL hsync_window: len=%0d start_clk=%0d expected 16 16", hs_cnt, hs_first);
        end
        n_cmp++;
        if (cb_cnt != 16 || cb_first != 32) begin
            n_err++;
            $display("FAIL cburst_window: len=%0d start_clk=%0d expected 16 32", cb_cnt, cb_first);
        end
        n_cmp++;
        if (hb_cnt != 64) begin
            n_err++;
            $display("FAIL hblank_len: got %0d expected 64", hb_cnt);
        end
    endtask

    task automatic test_wsync();
        int unsigned e;
        int  n;
        bit  seen;
        bit  early;
        goto_idx(20);
        wsync = 1'b1;
        exp_q.push_back(0);
        tick();
        wsync = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (rdy !== e[0]) begin
            n_err++;
            $display("FAIL wsync_halt: rdy=%b expected %b", rdy, e[0]);
        end
        seen = 1'b0; early = 1'b0; n = 0;
        while (!seen && n < 300) begin
            if (line_start === 1'b1) begin
                seen = 1'b1;
                if (rdy !== 1'b0) early = 1'b1;
                exp_q.push_back(1);
                tick();
                e = exp_q.pop_front();
                n_cmp++;
                if (rdy !== e[0]) begin
                    n_err++;
                    $display("FAIL wsync_release: rdy=%b expected %b", rdy, e[0]);
                end
            end else begin
                if (rdy !== 1'b0) early = 1'b1;
                tick();
                n++;
            end
        end
        n_cmp++;
        if (!seen || early) begin
            n_err++;
            $display("FAIL wsync_hold: line_start_seen=%b early_release=%b expected 1 0", seen, early);
        end

        // WSYNC on the line_start cycle itself holds until the following line.
        wait_line_start();
        wsync = 1'b1;
        tick();
        wsync = 1'b0;
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_err++;
            $display("FAIL wsync_on_start: rdy=%b expected 0", rdy);
        end
        wait_line_start();
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_err++;
            $display("FAIL wsync_on_start_hold: rdy=%b expected 0", rdy);
        end
        tick();
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL wsync_on_start_release: rdy=%b expected 1", rdy);
        end
    endtask

    task automatic test_rsync();
        goto_idx(30);
        wsync = 1'b1;
        tick();
        wsync = 1'b0;
        n_cmp++;
        if (rdy !== 1'b0 || phi1 !== 1'b0 || hindex !== 6'd30) begin
            n_err++;
            $display("FAIL rsync_setup: rdy=%b phi1=%b hindex=%0d expected 0 0 30", rdy, phi1, hindex);
        end
        rsync = 1'b1;
        tick();
        rsync = 1'b0;
        n_cmp++;
        if ({phi1, phi2, hindex, hcount, hblank, hsync, cburst, line_start, rdy}
            !== {1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rsync_restart: phi1=%b phi2=%b hindex=%0d hcount=%h hblank=%b hsync=%b cburst=%b line_start=%b rdy=%b expected 1 0 0 00 1 0 0 1 0",
                     phi1, phi2, hindex, hcount, hblank, hsync, cburst, line_start, rdy);
        end
        tick();
        n_cmp++;
        if (rdy !== 1'b1 || line_start !== 1'b0 || phi1 !== 1'b0 || hindex !== 6'd0) begin
            n_err++;
            $display("FAIL rsync_after: rdy=%b line_start=%b phi1=%b hindex=%0d expected 1 0 0 0",
                     rdy, line_start, phi1, hindex);
        end

        // RSYNC on the wrap edge: exactly one line_start pulse, index 0.
        goto_idx(56);
        repeat (3) tick();
        rsync = 1'b1;
        tick();
        rsync = 1'b0;
        n_cmp++;
        if (line_start !== 1'b1 || hindex !== 6'd0 || phi1 !== 1'b1) begin
            n_err++;
            $display("FAIL rsync_wrap: line_start=%b hindex=%0d phi1=%b expected 1 0 1", line_start, hindex, phi1);
        end
        tick();
        n_cmp++;
        if (line_start !== 1'b0 || hindex !== 6'd0) begin
            n_err++;
            $display("FAIL rsync_wrap_single: line_start=%b hindex=%0d expected 0 0", line_start, hindex);
        end
    endtask

    task automatic test_hmove();
        int unsigned e;
        int n;
        int len;
        // HMOVE early in a line stretches that line's blank (when enabled).
        goto_idx(2);
        hmove = 1'b1;
        exp_q.push_back(C_LATE_FALL_IDX);
        tick();
        hmove = 1'b0;
        n = 0;
        while (hblank === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (hindex !== e[5:0]) begin
            n_err++;
            $display("FAIL hmove_fall_idx: hblank fell at idx %0d expected %0d", hindex, e);
        end

        // HMOVE on the wrap edge marks the new line; the following line is normal.
        goto_idx(56);
        repeat (3) tick();
        hmove = 1'b1;
        exp_q.push_back(C_LATE_LEN);
        exp_q.push_back(64);
        tick();
        hmove = 1'b0;
        len = 0;
        while (hblank === 1'b1 && len < 300) begin
            len++;
            tick();
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (len != int'(e)) begin
            n_err++;
            $display("FAIL hmove_line_len: hblank %0d clk expected %0d", len, e);
        end
        wait_line_start();
        len = 0;
        while (hblank === 1'b1 && len < 300) begin
            len++;
            tick();
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (len != int'(e)) begin
            n_err++;
            $display("FAIL hmove_next_len: hblank %0d clk expected %0d", len, e);
        end
    endtask

    task automatic test_async_reset();
        goto_idx(10);
        tick();
        n_cmp++;
        if (hindex !== 6'd10 || phi1 !== 1'b0 || phi2 !== 1'b0) begin
            n_err++;
            $display("FAIL areset_setup: hindex=%0d phi1=%b phi2=%b expected 10 0 0", hindex, phi1, phi2);
        end
        rl = 1'b0;
        #1;
        n_cmp++;
        if (out_vec() !== C_RESET_VEC) begin
            n_err++;
            $display("FAIL areset_async: got %b expected %b", out_vec(), C_RESET_VEC);
        end
        tick();
        rl = 1'b1;
        tick();
        n_cmp++;
        if (phi1 !== 1'b0 || hindex !== 6'd0 || hblank !== 1'b1) begin
            n_err++;
            $display("FAIL areset_resume: phi1=%b hindex=%0d hblank=%b expected 0 0 1", phi1, hindex, hblank);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_free_run();
        test_wsync();
        test_rsync();
        test_hmove();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
